// File: rtl/mario_coin_if.sv
// Handshake/status bundle between level/tile logic, the coin tracker and HUD/score logic.
interface mario_coin_if #(
    parameter int NUM_COINS   = 8,
    parameter int TILE_W      = 8,
    parameter int COUNT_WIDTH = 8
);
    localparam int IDX_W = $clog2(NUM_COINS);

    logic                          frame_start;
    logic                          level_load;
    logic signed [31:0]            mario_x;
    logic signed [31:0]            mario_y;
    logic [NUM_COINS*TILE_W-1:0]   coin_x_flat;
    logic [NUM_COINS*TILE_W-1:0]   coin_y_flat;
    logic [NUM_COINS-1:0]          coin_valid;
    logic                          busy;
    logic                          scan_done;
    logic                          collect;
    logic [IDX_W-1:0]              collect_idx;
    logic [NUM_COINS-1:0]          coin_active;
    logic [COUNT_WIDTH-1:0]        coin_count;
    logic                          one_up;

    modport master (
        output frame_start, level_load, mario_x, mario_y, coin_x_flat, coin_y_flat, coin_valid,
        input  busy, scan_done, collect, collect_idx, coin_active, coin_count, one_up
    );

    modport slave (
        input  frame_start, level_load, mario_x, mario_y, coin_x_flat, coin_y_flat, coin_valid,
        output busy, scan_done, collect, collect_idx, coin_active, coin_count, one_up
    );
endinterface

// File: rtl/mario_coin_tracker.sv
// Multi-slot coin tracker: one shared hitbox comparator scans one slot per clock after frame_start.
// Optional extra-life rollover enabled by defining COIN_LIFE_EN.
module mario_coin_tracker #(
    parameter int NUM_COINS       = 8,
    parameter int CHARACTER_WIDTH = 42,
    parameter int BLOCK_WIDTH     = 40,
    parameter int HITBOX_INSET    = 10,
    parameter int TILE_W          = 8,
    parameter int COUNT_WIDTH     = 8,
    parameter int LIFE_THRESHOLD  = 100
) (
    input  logic          clk,
    input  logic          reset,
    mario_coin_if.slave   bus
);
    localparam int                     IDX_W     = $clog2(NUM_COINS);
    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_COINS - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    if (NUM_COINS < 2 || LIFE_THRESHOLD < 1 || LIFE_THRESHOLD > (2**COUNT_WIDTH) - 1) begin : g_bad_cfg
        $error("mario_coin_tracker: NUM_COINS or LIFE_THRESHOLD out of range");
    end

    typedef enum logic [1:0] {IDLE, CALC, SCAN, DONE} state_t;
    state_t state, state_next;

    logic signed [31:0]     mario_x_p0, mario_y_p0;
    logic [TILE_W-1:0]      tile_l_p1, tile_r_p1, tile_t_p1, tile_b_p1;
    logic [IDX_W-1:0]       idx;
    logic [TILE_W-1:0]      cur_x, cur_y;
    logic                   hit;
    logic [NUM_COINS-1:0]   coin_active_r;
    logic [COUNT_WIDTH-1:0] coin_count_r;
    logic                   collect_r, scan_done_r, one_up_r;
    logic [IDX_W-1:0]       collect_idx_r;

    function automatic logic signed [31:0] clamp_pos(input logic signed [31:0] v);
        return v[31] ? 32'sd0 : v;
    endfunction

    function automatic logic [TILE_W-1:0] to_tile(input logic signed [31:0] pix);
        return TILE_W'(pix / BLOCK_WIDTH);
    endfunction

    // Returns {one_up, next_count} for a single collected coin.
    function automatic logic [COUNT_WIDTH:0] bump_count(input logic [COUNT_WIDTH-1:0] c);
`ifdef COIN_LIFE_EN
        if (c == COUNT_WIDTH'(LIFE_THRESHOLD - 1))
            return {1'b1, {COUNT_WIDTH{1'b0}}};
        return {1'b0, c + COUNT_WIDTH'(1)};
`else
        if (c == COUNT_MAX)
            return {1'b0, c};
        return {1'b0, c + COUNT_WIDTH'(1)};
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.frame_start) state_next = CALC;
            CALC:    state_next = SCAN;
            SCAN:    if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.level_load)
            state_next = IDLE;
    end

    always_comb begin
        cur_x = bus.coin_x_flat[idx*TILE_W +: TILE_W];
        cur_y = bus.coin_y_flat[idx*TILE_W +: TILE_W];
        hit   = (state == SCAN) && coin_active_r[idx] &&
                (cur_x == tile_l_p1 || cur_x == tile_r_p1) &&
                (cur_y == tile_t_p1 || cur_y == tile_b_p1);
    end

    // Stage p0: latch clamped position on frame_start; stage p1: hitbox edges mapped to tiles.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.frame_start) begin
            mario_x_p0 <= clamp_pos(bus.mario_x);
            mario_y_p0 <= clamp_pos(bus.mario_y);
        end
        if (state == CALC) begin
            tile_l_p1 <= to_tile(mario_x_p0 + HITBOX_INSET);
            tile_r_p1 <= to_tile(mario_x_p0 - HITBOX_INSET + CHARACTER_WIDTH);
            tile_t_p1 <= to_tile(mario_y_p0 + HITBOX_INSET);
            tile_b_p1 <= to_tile(mario_y_p0 - HITBOX_INSET + CHARACTER_WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx           <= '0;
            collect_r     <= 1'b0;
            scan_done_r   <= 1'b0;
            one_up_r      <= 1'b0;
            collect_idx_r <= '0;
            coin_active_r <= '0;
            coin_count_r  <= '0;
        end else if (bus.level_load) begin
            coin_active_r <= bus.coin_valid;
            collect_r     <= 1'b0;
            scan_done_r   <= 1'b0;
            one_up_r      <= 1'b0;
        end else begin
            collect_r   <= 1'b0;
            one_up_r    <= 1'b0;
            scan_done_r <= (state == DONE);
            if (state == CALC)
                idx <= '0;
            else if (state == SCAN)
                idx <= idx + IDX_W'(1);
            if (hit) begin
                coin_active_r[idx]         <= 1'b0;
                collect_r                  <= 1'b1;
                collect_idx_r              <= idx;
                {one_up_r, coin_count_r}   <= bump_count(coin_count_r);
            end
        end
    end

    assign bus.busy        = (state == CALC) || (state == SCAN);
    assign bus.scan_done   = scan_done_r;
    assign bus.collect     = collect_r;
    assign bus.collect_idx = collect_idx_r;
    assign bus.coin_active = coin_active_r;
    assign bus.coin_count  = coin_count_r;
    assign bus.one_up      = one_up_r;
endmodule

// File: tb/tb_mario_coin_tracker.sv
// Self-checking bench for mario_coin_tracker: directed scenarios plus randomized passes vs. a geometric model.
module tb_mario_coin_tracker;
    localparam int NC   = 4;
    localparam int TW   = 8;
    localparam int CWID = 3;
    localparam int LT   = 5;
    localparam int CW   = 42;
    localparam int BW   = 40;
    localparam int INS  = 10;
    localparam int CMAX = (1 << CWID) - 1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [NC-1:0] m_active;
    int            m_count;
    int            total_hits;
    logic [TW-1:0] m_cx [NC];
    logic [TW-1:0] m_cy [NC];

    mario_coin_if #(.NUM_COINS(NC), .TILE_W(TW), .COUNT_WIDTH(CWID)) bus ();

    mario_coin_tracker #(
        .NUM_COINS(NC), .CHARACTER_WIDTH(CW), .BLOCK_WIDTH(BW), .HITBOX_INSET(INS),
        .TILE_W(TW), .COUNT_WIDTH(CWID), .LIFE_THRESHOLD(LT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Tiles covered by the inset hitbox: first and last pixel of the trimmed sprite, divided by tile size.
    function automatic int first_tile(input int p);
        int q = (p < 0) ? 0 : p;
        return (q + INS) / BW;
    endfunction

    function automatic int last_tile(input int p);
        int q = (p < 0) ? 0 : p;
        return (q + CW - INS) / BW;
    endfunction

    task automatic model_collect(output bit up);
        up = 1'b0;
        total_hits++;
`ifdef COIN_LIFE_EN
        if (m_count + 1 == LT) begin
            m_count = 0;
            up = 1'b1;
        end else begin
            m_count = (m_count + 1) % (CMAX + 1);
        end
`else
        if (m_count < CMAX) m_count = m_count + 1;
`endif
    endtask

    task automatic place_coins();
        for (int k = 0; k < NC; k++) begin
            bus.coin_x_flat[k*TW +: TW] = m_cx[k];
            bus.coin_y_flat[k*TW +: TW] = m_cy[k];
        end
    endtask

    task automatic load_level(input logic [NC-1:0] v);
        @(negedge clk);
        place_coins();
        bus.coin_valid = v;
        bus.level_load = 1'b1;
        @(negedge clk);
        bus.level_load = 1'b0;
        m_active = v;
        checks++;
        if (bus.coin_active !== m_active || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL load_level: coin_active=%b busy=%b, required %b busy=0", bus.coin_active, bus.busy, m_active);
        end
    endtask

    task automatic run_pass(input int mx, input int my, input bit extra_fs, input string tag);
        bit exp_hit [NC];
        bit hit_now;
        bit up;
        int lx, hx, ly, hy;
        lx = first_tile(mx); hx = last_tile(mx);
        ly = first_tile(my); hy = last_tile(my);
        for (int k = 0; k < NC; k++)
            exp_hit[k] = m_active[k] && (int'(m_cx[k]) == lx || int'(m_cx[k]) == hx) &&
                         (int'(m_cy[k]) == ly || int'(m_cy[k]) == hy);
        @(negedge clk);
        bus.mario_x     = mx;
        bus.mario_y     = my;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = extra_fs;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy@0: got %b, required 1", tag, bus.busy);
        end
        for (int c = 1; c <= NC + 4; c++) begin
            @(negedge clk);
            bus.frame_start = extra_fs && (c < NC + 2);
            hit_now = 1'b0;
            up = 1'b0;
            if (c >= 2 && c <= NC + 1) hit_now = exp_hit[c-2];
            if (hit_now) begin
                model_collect(up);
                m_active[c-2] = 1'b0;
            end
            checks++;
            if (bus.collect !== hit_now || (hit_now && bus.collect_idx !== (c - 2))) begin
                errors++;
                $display("FAIL %s collect@%0d: got %b idx %0d, required %b idx %0d",
                         tag, c, bus.collect, bus.collect_idx, hit_now, c - 2);
            end
            checks++;
            if (bus.coin_count !== CWID'(m_count) || bus.one_up !== up) begin
                errors++;
                $display("FAIL %s count@%0d: got %0d one_up %b, required %0d one_up %b",
                         tag, c, bus.coin_count, bus.one_up, m_count, up);
            end
            checks++;
            if (bus.scan_done !== (c == NC + 2) || bus.busy !== (c <= NC)) begin
                errors++;
                $display("FAIL %s status@%0d: got scan_done %b busy %b, required %b %b",
                         tag, c, bus.scan_done, bus.busy, (c == NC + 2), (c <= NC));
            end
        end
        checks++;
        if (bus.coin_active !== m_active) begin
            errors++;
            $display("FAIL %s coin_active: got %b, required %b", tag, bus.coin_active, m_active);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.frame_start = 1'b0; bus.level_load = 1'b0;
        bus.mario_x = 0; bus.mario_y = 0;
        bus.coin_x_flat = '0; bus.coin_y_flat = '0; bus.coin_valid = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_active = '0; m_count = 0; total_hits = 0;
        checks++;
        if (bus.busy !== 1'b0 || bus.scan_done !== 1'b0 || bus.collect !== 1'b0 || bus.one_up !== 1'b0 ||
            bus.collect_idx !== '0 || bus.coin_active !== '0 || bus.coin_count !== '0) begin
            errors++;
            $display("FAIL reset: busy %b done %b collect %b one_up %b idx %0d active %b count %0d, required all 0",
                     bus.busy, bus.scan_done, bus.collect, bus.one_up, bus.collect_idx, bus.coin_active, bus.coin_count);
        end
    endtask

    task automatic test_single_coin();
        for (int k = 0; k < NC; k++) begin m_cx[k] = '0; m_cy[k] = '0; end
        m_cx[2] = 8'd3; m_cy[2] = 8'd5;
        load_level(4'b0111);
        run_pass(110, 190, 1'b0, "single");
        checks++;
        if (bus.coin_count !== CWID'(1) || bus.coin_active !== 4'b0011) begin
            errors++;
            $display("FAIL single_final: count %0d active %b, required 1 and 0011", bus.coin_count, bus.coin_active);
        end
        run_pass(110, 190, 1'b0, "repeat");
        checks++;
        if (bus.coin_count !== CWID'(1)) begin
            errors++;
            $display("FAIL repeat_final: count %0d, required 1", bus.coin_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < NC; k++) begin m_cx[k] = '0; m_cy[k] = '0; end
        m_cx[0] = 8'd3; m_cy[0] = 8'd5; m_cx[1] = 8'd3; m_cy[1] = 8'd5;
        load_level(4'b0011);
        run_pass(110, 190, 1'b0, "back_to_back");
    endtask

    task automatic test_ignored_frame_start();
        for (int k = 0; k < NC; k++) begin m_cx[k] = 8'd2; m_cy[k] = 8'd0; end
        load_level(4'b1111);
        run_pass(70, -15, 1'b1, "ignore_fs");
    endtask

    task automatic test_level_load_mid_scan();
        int cnt_before;
        for (int k = 0; k < NC; k++) begin m_cx[k] = 8'd3; m_cy[k] = 8'd5; end
        load_level(4'b1111);
        cnt_before = m_count;
        @(negedge clk);
        bus.mario_x = 600; bus.mario_y = 600; bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (3) @(negedge clk);
        bus.coin_valid = 4'b1010;
        bus.level_load = 1'b1;
        @(negedge clk);
        bus.level_load = 1'b0;
        m_active = 4'b1010;
        checks++;
        if (bus.busy !== 1'b0 || bus.coin_active !== 4'b1010 || bus.coin_count !== CWID'(cnt_before)) begin
            errors++;
            $display("FAIL mid_load: busy %b active %b count %0d, required 0 1010 %0d",
                     bus.busy, bus.coin_active, bus.coin_count, cnt_before);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (bus.scan_done !== 1'b0 || bus.busy !== 1'b0 || bus.collect !== 1'b0) begin
                errors++;
                $display("FAIL mid_load_quiet@%0d: done %b busy %b collect %b, required 0 0 0",
                         c, bus.scan_done, bus.busy, bus.collect);
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < NC; k++) begin m_cx[k] = 8'd3; m_cy[k] = 8'd5; end
        for (int r = 0; r < 3; r++) begin
            load_level(4'b1111);
            run_pass(110, 190, 1'b0, "saturate");
        end
`ifndef COIN_LIFE_EN
        checks++;
        if (total_hits >= CMAX && bus.coin_count !== CWID'(CMAX)) begin
            errors++;
            $display("FAIL saturate_final: count %0d, required %0d", bus.coin_count, CMAX);
        end
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < NC; k++) begin
                m_cx[k] = TW'($urandom_range(0, 8));
                m_cy[k] = TW'($urandom_range(0, 8));
            end
            load_level(NC'($urandom_range(0, (1 << NC) - 1)));
            for (int p = 0; p < 2; p++)
                run_pass(int'($urandom_range(0, 340)) - 30, int'($urandom_range(0, 340)) - 30,
                         1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_coin();
        test_back_to_back();
        test_ignored_frame_start();
        test_level_load_mid_scan();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
